// File: rtl/cp0_ctrl.sv
// CP0 exception/ERET/MTC0 sequencer: owns the CP0 register-file write port and
// keeps status/EPC shadows for EXL handling, interrupt gating and ERET redirect.
module cp0_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        eret_req,
  input  logic        mtc0_req,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  output logic        mtc0_ack,
  input  logic [5:0]  hw_int,
  output logic        busy,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        int_pending,
  output logic [31:0] epc,
  output logic [4:0]  cp0_waddr,
  output logic [3:0]  cp0_wen,
  output logic [31:0] cp0_wdata
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;
  localparam logic [31:0] EXL_MASK   = 32'h0000_0002;

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_STATUS,
    E_STATUS
  } state_t;

  state_t      state;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        bd_q;
  logic [31:0] status;
  logic [31:0] epc_q;

  logic        idle_ok;
  logic        acc_exc;
  logic        acc_eret;
  logic        acc_mtc0;
  logic [31:0] epc_val;

  // Reset gates acceptance so nothing is acked while rst is held.
  assign idle_ok  = (state == IDLE) && !rst;
  assign acc_exc  = idle_ok && exc_req;
  assign acc_eret = idle_ok && !exc_req && eret_req;
  assign acc_mtc0 = idle_ok && !exc_req && !eret_req && mtc0_req;
  assign epc_val  = bd_q ? 32'(pc_q - 32'd4) : pc_q;

  assign busy = (state != IDLE);
  assign epc  = epc_q;

  // Write port, flush and redirect are decoded from the current state (and the
  // MTC0 request in IDLE, which is written in the same cycle it is acked).
  always_comb begin
    mtc0_ack    = 1'b0;
    cp0_waddr   = 5'd0;
    cp0_wen     = 4'h0;
    cp0_wdata   = 32'd0;
    flush       = 1'b0;
    redirect_pc = 32'd0;
    case (state)
      IDLE: begin
        if (acc_mtc0) begin
          mtc0_ack  = 1'b1;
          cp0_waddr = mtc0_addr;
          cp0_wen   = 4'hF;
          cp0_wdata = mtc0_wdata;
        end
      end
      W_EPC: begin
        cp0_waddr = ADDR_EPC;
        cp0_wen   = 4'hF;
        cp0_wdata = epc_val;
      end
      W_CAUSE: begin
        cp0_waddr = ADDR_CAUSE;
        cp0_wen   = 4'hF;
        cp0_wdata = {bd_q, 15'b0, hw_int, 3'b0, code_q, 2'b0};
      end
      W_STATUS: begin
        cp0_waddr   = ADDR_STATUS;
        cp0_wen     = 4'hF;
        cp0_wdata   = status | EXL_MASK;
        flush       = 1'b1;
        redirect_pc = EXC_VECTOR;
      end
      E_STATUS: begin
        cp0_waddr   = ADDR_STATUS;
        cp0_wen     = 4'hF;
        cp0_wdata   = status & ~EXL_MASK;
        flush       = 1'b1;
        redirect_pc = epc_q;
      end
      default: ;
    endcase
  end

  // Cause is never read back here, so only status and EPC are shadowed; both
  // follow whatever this block writes to their register-file addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      code_q      <= 5'd0;
      pc_q        <= 32'd0;
      bd_q        <= 1'b0;
      status      <= 32'd0;
      epc_q       <= 32'd0;
      int_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_exc) begin
            code_q <= exc_code;
            pc_q   <= exc_pc;
            bd_q   <= exc_bd;
            state  <= W_EPC;
          end else if (acc_eret) begin
            state <= E_STATUS;
          end
        end
        W_EPC:    state <= W_CAUSE;
        W_CAUSE:  state <= W_STATUS;
        W_STATUS: state <= IDLE;
        E_STATUS: state <= IDLE;
        default:  state <= IDLE;
      endcase

      if (cp0_wen != 4'h0) begin
        if (cp0_waddr == ADDR_STATUS) status <= cp0_wdata;
        if (cp0_waddr == ADDR_EPC)    epc_q  <= cp0_wdata;
      end

      if (state == W_STATUS) int_pending <= 1'b0;
      else int_pending <= status[0] & ~status[1] & (|(hw_int & status[15:10]));
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: driver pushes expected register-file writes
// from a behavioural CP0 model; a negedge monitor pops and compares them.
module tb_cp0_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_req = 1'b0;
  logic [4:0]  exc_code = 5'd0;
  logic [31:0] exc_pc = 32'd0;
  logic        exc_bd = 1'b0;
  logic        eret_req = 1'b0;
  logic        mtc0_req = 1'b0;
  logic [4:0]  mtc0_addr = 5'd0;
  logic [31:0] mtc0_wdata = 32'd0;
  logic        mtc0_ack;
  logic [5:0]  hw_int = 6'd0;
  logic        busy;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        int_pending;
  logic [31:0] epc;
  logic [4:0]  cp0_waddr;
  logic [3:0]  cp0_wen;
  logic [31:0] cp0_wdata;

  cp0_ctrl #(.EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .eret_req(eret_req),
    .mtc0_req(mtc0_req), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata), .mtc0_ack(mtc0_ack),
    .hw_int(hw_int), .busy(busy), .flush(flush), .redirect_pc(redirect_pc),
    .int_pending(int_pending), .epc(epc),
    .cp0_waddr(cp0_waddr), .cp0_wen(cp0_wen), .cp0_wdata(cp0_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        flush;
    logic [31:0] redir;
    logic        ack;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  // Architectural model of the CP0 state this block is responsible for.
  logic [31:0] m_status = 32'd0;
  logic [31:0] m_epc = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [4:0] a, input logic [31:0] d,
                      input logic f, input logic [31:0] r, input logic ack);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d; w.flush = f; w.redir = r; w.ack = ack;
    exp_q.push_back(w);
  endtask

  function automatic logic exp_int(input logic [31:0] st, input logic [5:0] h);
    return st[0] && !st[1] && ((h & st[15:10]) != 6'd0);
  endfunction

  // Exception accepted at the edge ending cycle k: EPC, Cause, Status follow.
  task automatic model_exc(input int k, input logic [4:0] code, input logic [31:0] pc, input logic bd);
    logic [31:0] ev;
    logic [31:0] cause;
    ev = bd ? pc - 32'd4 : pc;
    cause = (32'(bd) << 31) | (32'(hw_int) << 10) | (32'(code) << 2);
    m_epc = ev;
    push(k + 1, 5'd14, ev, 1'b0, 32'd0, 1'b0);
    push(k + 2, 5'd13, cause, 1'b0, 32'd0, 1'b0);
    m_status = m_status | 32'h2;
    push(k + 3, 5'd12, m_status, 1'b1, VEC, 1'b0);
  endtask

  task automatic model_mtc0(input int k, input logic [4:0] a, input logic [31:0] d);
    push(k, a, d, 1'b0, 32'd0, 1'b1);
    if (a == 5'd12) m_status = d;
    if (a == 5'd14) m_epc = d;
  endtask

  task automatic do_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd);
    int k;
    k = cyc;
    exc_code = code; exc_pc = pc; exc_bd = bd; exc_req = 1'b1;
    model_exc(k, code, pc, bd);
    step();
    exc_req = 1'b0;
    exc_pc = $urandom; exc_code = 5'($urandom); exc_bd = 1'($urandom);
    chk("busy_in_seq", 32'(busy), 32'd1);
    step(); step(); step();
    chk("busy_after_seq", 32'(busy), 32'd0);
    chk("int_pending_after_exc", 32'(int_pending), 32'd0);
    chk("epc_shadow", epc, m_epc);
  endtask

  task automatic do_eret();
    int k;
    k = cyc;
    eret_req = 1'b1;
    m_status = m_status & ~32'h2;
    push(k + 1, 5'd12, m_status, 1'b1, m_epc, 1'b0);
    step();
    eret_req = 1'b0;
    step();
  endtask

  task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_addr = a; mtc0_wdata = d; mtc0_req = 1'b1;
    model_mtc0(cyc, a, d);
    step();
    mtc0_req = 1'b0;
  endtask

  task automatic settle(input logic [5:0] h);
    hw_int = h;
    step(); step();
    chk("int_pending", 32'(int_pending), 32'(exp_int(m_status, h)));
  endtask

  // All three requests together: exception first, ERET in the next IDLE cycle, then MTC0.
  task automatic do_all3();
    int k;
    logic [31:0] d;
    k = cyc;
    d = $urandom;
    exc_code = 5'h04; exc_pc = 32'h8000_2000; exc_bd = 1'b0; exc_req = 1'b1;
    eret_req = 1'b1;
    mtc0_addr = 5'd14; mtc0_wdata = d; mtc0_req = 1'b1;
    model_exc(k, 5'h04, 32'h8000_2000, 1'b0);
    m_status = m_status & ~32'h2;
    push(k + 5, 5'd12, m_status, 1'b1, m_epc, 1'b0);
    model_mtc0(k + 6, 5'd14, d);
    step();
    exc_req = 1'b0;
    step(); step(); step(); step();
    eret_req = 1'b0;
    step(); step();
    mtc0_req = 1'b0;
  endtask

  // Reset mid W_CAUSE, with an MTC0 held across reset.
  task automatic do_reset_mid();
    int k;
    logic [31:0] d;
    k = cyc;
    d = $urandom;
    exc_code = 5'h0A; exc_pc = 32'h8000_4444; exc_bd = 1'b0; exc_req = 1'b1;
    push(k + 1, 5'd14, 32'h8000_4444, 1'b0, 32'd0, 1'b0);
    step();
    exc_req = 1'b0;
    step();
    rst = 1'b1;
    mtc0_addr = 5'd13; mtc0_wdata = d; mtc0_req = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wen", 32'(cp0_wen), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_int_pending", 32'(int_pending), 32'd0);
    chk("rst_ack", 32'(mtc0_ack), 32'd0);
    step(); step();
    m_status = 32'd0; m_epc = 32'd0;
    rst = 1'b0;
    model_mtc0(cyc, 5'd13, d);
    step();
    mtc0_req = 1'b0;
  endtask

  // Monitor: every write must match the head of the scoreboard, else port idle.
  always @(negedge clk) begin
    wr_t e;
    if (cp0_wen != 4'h0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_wen", 32'(cp0_wen), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_cycle", 32'(cyc), 32'(e.cyc));
        chk("write_wen", 32'(cp0_wen), 32'hF);
        chk("write_addr", 32'(cp0_waddr), 32'(e.addr));
        chk("write_data", cp0_wdata, e.data);
        chk("write_flush", 32'(flush), 32'(e.flush));
        chk("write_redirect", redirect_pc, e.redir);
        chk("write_ack", 32'(mtc0_ack), 32'(e.ack));
      end
    end else begin
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_write_wen", 32'(cp0_wen), 32'hF);
      end
      chk("idle_waddr", 32'(cp0_waddr), 32'd0);
      chk("idle_wdata", cp0_wdata, 32'd0);
      chk("idle_flush", 32'(flush), 32'd0);
      chk("idle_redirect", redirect_pc, 32'd0);
      chk("idle_ack", 32'(mtc0_ack), 32'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    int sel;
    logic [4:0] a;
    step(); step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_epc", epc, 32'd0);
    chk("reset_int_pending", 32'(int_pending), 32'd0);
    chk("reset_wen", 32'(cp0_wen), 32'd0);
    rst = 1'b0;
    step();

    do_exc(5'h0C, 32'h8000_1000, 1'b0);
    do_eret();
    hw_int = 6'b000001;
    do_exc(5'h0C, 32'h8000_1000, 1'b1);
    do_eret();

    do_mtc0(5'd12, 32'h0000_FC01);
    hw_int = 6'b100000;
    step();
    chk("int_pending_set", 32'(int_pending), 32'd1);
    do_exc(5'h00, 32'h8000_3000, 1'b0);
    do_eret();

    do_all3();
    do_reset_mid();
    do_mtc0(5'd0, 32'h1234_5678);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: do_exc(5'($urandom), $urandom, 1'($urandom));
        1: do_eret();
        2: begin
          sel = $urandom_range(0, 4);
          case (sel)
            0: a = 5'd0;
            1: a = 5'd12;
            2: a = 5'd13;
            3: a = 5'd14;
            default: a = 5'($urandom);
          endcase
          do_mtc0(a, $urandom);
        end
        default: settle(6'($urandom));
      endcase
    end

    repeat (5) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
